// File: rtl/uart_frame_buffer.sv
// Ping-pong receive-frame buffer: UART bytes fill one bank while the CPU
// reads the completed frame and status through a registered read window.
module uart_frame_buffer #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 5,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              flush,
    input  logic              ack,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] r_data,
    output logic              full,
    output logic              overrun,
    output logic [ADDR_W-1:0] wr_count
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] STAT = ADDR_W'(FRAME_LEN);

    logic [DATA_W-1:0] mem_q [2][FRAME_LEN];
    logic [DATA_W-1:0] mem_d [2][FRAME_LEN];
    logic              wbank_q, wbank_d;
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;

    logic wr_eff;
    logic complete;
    logic accept;
    logic [DATA_W-1:0] status;

    assign wr_eff   = wr && !flush;
    assign complete = wr_eff && (w_ptr_q == LAST);
    // A completed frame only swaps banks if the ready one is free or
    // being released this very cycle; otherwise it is dropped.
    assign accept   = complete && (!full_q || ack);

    always_comb begin
        status    = '0;
        status[0] = full_q;
        status[1] = overrun_q;
    end

    always_comb begin
        mem_d     = mem_q;
        w_ptr_d   = w_ptr_q;
        wbank_d   = wbank_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        r_data_d  = '0;

        if (wr_eff) begin
            mem_d[wbank_q][w_ptr_q] = w_data;
        end

        if (flush || complete) begin
            w_ptr_d = '0;
        end else if (wr_eff) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end

        if (accept) begin
            wbank_d = ~wbank_q;
        end

        if (accept) begin
            full_d = 1'b1;
        end else if (ack) begin
            full_d = 1'b0;
        end

        if (ack) begin
            overrun_d = 1'b0;
        end else if (complete && full_q) begin
            overrun_d = 1'b1;
        end

        if (address < STAT) begin
            r_data_d = mem_q[~wbank_q][address];
        end else if (address == STAT) begin
            r_data_d = status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
            wbank_q   <= 1'b0;
            w_ptr_q   <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            mem_q     <= mem_d;
            wbank_q   <= wbank_d;
            w_ptr_q   <= w_ptr_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            r_data_q  <= r_data_d;
        end
    end

    assign r_data   = r_data_q;
    assign full     = full_q;
    assign overrun  = overrun_q;
    assign wr_count = w_ptr_q;

endmodule

// File: doc/uart_frame_buffer.md
# uart_frame_buffer

Parametrised receive-frame buffer between the UART receiver and the CPU-side memory map. It collects `FRAME_LEN` bytes from the receiver into one of two ping-pong banks. A completed frame is presented to the CPU as an address-mapped, read-only window with a status word. The receiver fills the other bank while the CPU reads, and lost frames are reported through a sticky overrun flag.

## Interface
- `DATA_W`, 8, byte width of each entry.
- `FRAME_LEN`, 5, bytes per frame; range 1..2^ADDR_W-1.
- `ADDR_W`, 3, read-address width; must satisfy 2^ADDR_W > FRAME_LEN.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wr`  in  1  one-cycle strobe: `w_data` is a received byte.
- `w_data`  in  DATA_W  received byte.
- `flush`  in  1  discard the partially filled write bank (resync).
- `ack`  in  1  one-cycle strobe: CPU has consumed the ready frame.
- `address`  in  ADDR_W  read index into the ready bank.
- `r_data`  out  DATA_W  registered read data.
- `full`  out  1  a complete frame is ready in the read bank.
- `overrun`  out  1  sticky: a completed frame was dropped.
- `wr_count`  out  ADDR_W  bytes in the current write bank, 0..FRAME_LEN-1.

## Operation
- State:
  - two banks of FRAME_LEN×DATA_W;
  - `wbank` (bank being written) and `w_ptr`;
  - `full` and `overrun`.
  - The read bank is always `!wbank`.
- Reset: both banks cleared to 0; `wbank`=0; `w_ptr`=0; `full`=0; `overrun`=0; `r_data`=0; `wr_count`=0.
- Write: on `wr`, store `w_data` at `bank[wbank][w_ptr]` and increment `w_ptr`.
- Frame completion: when `wr` occurs with `w_ptr`==FRAME_LEN-1, the frame is complete and `w_ptr` wraps to 0.
  - If `full`=0, or `ack` is asserted in the same cycle: toggle `wbank` and set `full`=1.
  - Otherwise (`full`=1, no `ack`): drop the frame. `wbank` is unchanged, the bank is reused from index 0, and `overrun` is set to 1. The ready frame is never overwritten.
- `ack`:
  - clears `full` and `overrun`;
  - `ack` while `full`=0 clears only `overrun`;
  - `ack` coincident with completion leaves `full`=1 and the new frame readable (see above).
- `flush`:
  - sets `w_ptr`=0 and drops any `wr` in the same cycle;
  - does not affect `full`, `overrun`, the read bank or `wbank`;
  - if `flush` and `ack` are asserted together, both take effect.
- Read map, registered:
  - `address` < FRAME_LEN → `bank[!wbank][address]`;
  - `address` == FRAME_LEN → status word {0…, `overrun`, `full`} (bit0 `full`, bit1 `overrun`), as the old fixed 5-byte layout used;
  - `address` > FRAME_LEN → 0.
- Bank contents are returned regardless of `full`; software checks status first.
- `wr_count` = `w_ptr`.

## Timing
- `wr` is sampled on the rising edge; byte storage and `wr_count` update are visible after that edge.
- `full` rises on the edge that samples the completing `wr`.
  - First `r_data` of the new frame: set `address` in the cycle after `full` rises; data is valid the following cycle.
- `r_data` latency: 1 cycle from `address`. Status reads reflect `full`/`overrun` as registered at the previous edge.
- `ack` takes effect on its sampling edge: `full`=0 in the next cycle, and the status read issued that cycle returns 0.
- Back-to-back `wr` every cycle is supported with no gaps; the frame after completion starts at index 0 in the next cycle.
- Asynchronous `rst_n` assertion mid-frame or mid-read returns everything to reset values immediately. Release is synchronised externally.

## Test plan
- Frame receive: reset, then 5 `wr` with 0x11..0x55, then read addresses 0..5 → 0x11..0x55, then 0x01; `wr_count` returns to 0.
- Ping-pong: after frame A (0x11..0x55), 3 `wr` of 0xA0..0xA2 without `ack` → reads still return A and `wr_count`=3. Then `ack` plus 2 more `wr` (0xA3, 0xA4) → `full`=1 and reads return 0xA0..0xA4.
- Overrun: frame A ready, no `ack`, 5 more `wr` of 0xB0..0xB4 → `full`=1, `overrun`=1, reads still return 0x11..0x55, status=0x03. Then `ack` → status=0x00.
- Simultaneous `ack` and completing `wr`: status stays 0x01, `overrun`=0, and reads return the new frame.
- Flush: 2 `wr`, then `flush` with a coincident `wr` of 0xEE → `wr_count`=0 and 0xEE is not stored. Then 5 `wr` of 0x01..0x05 → frame reads 0x01..0x05.
- Async reset mid-frame: 3 `wr`, then `rst_n`=0 between edges → `full`, `overrun`, `wr_count` and `r_data` all 0 immediately; address 6 reads 0.
